// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported memory bus
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_STREAK     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_ack_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_ack_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          grant_d;
    logic          grant_i;
    logic          done;
    logic          expire;

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (data_req_i && (!inst_req_i || streak < STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (inst_req_i) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            streak       <= '0;
            tcnt         <= '0;
            inst_ack_o   <= 1'b0;
            inst_rdata_o <= '0;
            data_ack_o   <= 1'b0;
            data_rdata_o <= '0;
            err_o        <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            state      <= state_next;
            inst_ack_o <= 1'b0;
            data_ack_o <= 1'b0;
            err_o      <= 1'b0;

            if (grant_d) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= data_we_i;
                mem_addr_o  <= data_addr_i;
                mem_wdata_o <= data_wdata_i;
                if (!inst_req_i)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else if (grant_i) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= inst_addr_i;
                streak     <= '0;
            end

            // A timed-out transfer returns zero data and flags err alongside its ack.
            if (done || expire) begin
                mem_req_o <= 1'b0;
                tcnt      <= '0;
                err_o     <= expire;
                if (state == BUSY_I) begin
                    inst_ack_o   <= 1'b1;
                    inst_rdata_o <= expire ? '0 : mem_rdata_i;
                end else begin
                    data_ack_o <= 1'b1;
                    if (expire)
                        data_rdata_o <= '0;
                    else if (!mem_we_o)
                        data_rdata_o <= mem_rdata_i;
                end
            end else if (state != IDLE) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_ack_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_ack_o;
    logic [31:0] data_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_ack_o(inst_ack_o), .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o),
        .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;   // -1: never ready
        int          len;      // expected mem_req_o high cycles, 0: unchecked
    } mem_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } ack_t;

    mem_t mq[$];
    ack_t aq[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_mem(bit we, logic [31:0] addr, logic [31:0] wdata,
                                     logic [31:0] rdata, int wait_n, int len);
        mem_t m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata;
        m.wait_n = wait_n; m.len = len;
        mq.push_back(m);
    endfunction

    function automatic void push_ack(bit is_data, logic [31:0] rdata, bit err);
        ack_t a;
        a.is_data = is_data; a.rdata = rdata; a.err = err;
        aq.push_back(a);
    endfunction

    // Memory responder: checks request fields every busy cycle and counts busy length.
    mem_t cur;
    int   bcnt = 0;
    bit   active = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            active = 1'b0; bcnt = 0; mem_ready_i = 1'b0;
        end else if (mem_req_o) begin
            if (!active) begin
                if (mq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_mem_req: addr 0x%0h expected none", mem_addr_o);
                    cur.we = mem_we_o; cur.addr = mem_addr_o; cur.wdata = mem_wdata_o;
                    cur.rdata = '0; cur.wait_n = 0; cur.len = 0;
                end else begin
                    cur = mq.pop_front();
                end
                active = 1'b1; bcnt = 0;
            end
            chk("mem_we", 64'(mem_we_o), 64'(cur.we));
            chk("mem_addr", 64'(mem_addr_o), 64'(cur.addr));
            if (cur.we) chk("mem_wdata", 64'(mem_wdata_o), 64'(cur.wdata));
            bcnt++;
            mem_ready_i = (cur.wait_n >= 0) && (bcnt > cur.wait_n);
            mem_rdata_i = mem_ready_i ? cur.rdata : 32'hBAD0BAD0;
        end else begin
            if (active && cur.len != 0) chk("mem_req_len", 64'(bcnt), 64'(cur.len));
            active = 1'b0; bcnt = 0; mem_ready_i = 1'b0;
        end
    end

    // Ack monitor
    ack_t e;
    always @(negedge clk) begin
        if (rst) begin
            if (inst_ack_o && data_ack_o) begin
                tests++; fails++;
                $display("FAIL ack_overlap: both acks high at %0t", $time);
            end
            if (err_o && !inst_ack_o && !data_ack_o) begin
                tests++; fails++;
                $display("FAIL err_alone: err_o=1 without ack at %0t", $time);
            end
            if (inst_ack_o || data_ack_o) begin
                if (aq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: inst=%0b data=%0b expected none", inst_ack_o, data_ack_o);
                end else begin
                    e = aq.pop_front();
                    chk("ack_kind_is_data", 64'(data_ack_o), 64'(e.is_data));
                    chk("ack_rdata", 64'(e.is_data ? data_rdata_o : inst_rdata_o), 64'(e.rdata));
                    chk("ack_err", 64'(err_o), 64'(e.err));
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, output int lat);
        inst_addr_i = a; inst_req_i = 1'b1; lat = 0;
        forever begin
            @(posedge clk); #1; lat++;
            if (inst_ack_o) break;
            if (lat > 300) begin
                tests++; fails++;
                $display("FAIL fetch_timeout: no ack for 0x%0h", a);
                break;
            end
        end
        inst_req_i = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit keep);
        int n;
        data_we_i = we; data_addr_i = a; data_wdata_i = wd; data_req_i = 1'b1; n = 0;
        forever begin
            @(posedge clk); #1; n++;
            if (data_ack_o) break;
            if (n > 300) begin
                tests++; fails++;
                $display("FAIL data_timeout: no ack for 0x%0h", a);
                break;
            end
        end
        if (!keep) data_req_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int lat;
        int acks;

        #2 rst = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req_o), 0);
        chk("rst_mem_we", 64'(mem_we_o), 0);
        chk("rst_mem_addr", 64'(mem_addr_o), 0);
        chk("rst_acks_err", 64'({inst_ack_o, data_ack_o, err_o}), 0);
        chk("rst_rdata", 64'({inst_rdata_o, data_rdata_o}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Single fetch
        push_mem(0, 32'h100, 0, 32'h00500093, 0, 1);
        push_ack(0, 32'h00500093, 0);
        do_fetch(32'h100, lat);
        chk("single_fetch_latency", 64'(lat), 2);

        // Simultaneous fetch + store: store first
        push_mem(1, 32'h1000, 32'hDEADBEEF, 0, 0, 1);
        push_mem(0, 32'h200, 0, 32'h12345678, 0, 1);
        push_ack(1, 32'h0, 0);
        push_ack(0, 32'h12345678, 0);
        fork
            do_fetch(32'h200, lat);
            do_data(1, 32'h1000, 32'hDEADBEEF, 0);
        join

        // Starvation guard: D D D D I D D
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                push_mem(0, 32'h300, 0, 32'h00000300, 0, 1);
                push_ack(0, 32'h00000300, 0);
            end
            push_mem(0, 32'h3000 + 32'(4 * k), 0, 32'hA0000000 + 32'(k), 0, 1);
            push_ack(1, 32'hA0000000 + 32'(k), 0);
        end
        fork
            do_fetch(32'h300, lat);
            for (int k = 0; k < 6; k++) do_data(0, 32'h3000 + 32'(4 * k), 0, k < 5);
        join

        // Streak back at zero: four data grants again before the fetch
        for (int k = 0; k < 4; k++) begin
            push_mem(0, 32'h3100 + 32'(4 * k), 0, 32'hB0000000 + 32'(k), 0, 1);
            push_ack(1, 32'hB0000000 + 32'(k), 0);
        end
        push_mem(0, 32'h310, 0, 32'h00000310, 0, 1);
        push_ack(0, 32'h00000310, 0);
        fork
            do_fetch(32'h310, lat);
            for (int k = 0; k < 4; k++) do_data(0, 32'h3100 + 32'(4 * k), 0, k < 3);
        join

        // Timeout on a load, then a normal fetch
        push_mem(0, 32'h2000, 0, 0, -1, 64);
        push_ack(1, 32'h0, 1);
        do_data(0, 32'h2000, 0, 0);
        push_mem(0, 32'h400, 0, 32'h00000413, 0, 1);
        push_ack(0, 32'h00000413, 0);
        do_fetch(32'h400, lat);
        chk("post_timeout_fetch_latency", 64'(lat), 2);

        // Wait states: load with 2, store with 3 (store leaves load data intact)
        push_mem(0, 32'h6004, 0, 32'h55AA55AA, 2, 3);
        push_ack(1, 32'h55AA55AA, 0);
        do_data(0, 32'h6004, 0, 0);
        push_mem(1, 32'h6000, 32'hCAFEF00D, 32'h0, 3, 4);
        push_ack(1, 32'h55AA55AA, 0);
        do_data(1, 32'h6000, 32'hCAFEF00D, 0);

        // Async reset during BUSY_D
        push_mem(1, 32'h7000, 32'h00000077, 0, -1, 0);
        data_we_i = 1'b1; data_addr_i = 32'h7000; data_wdata_i = 32'h77; data_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_mem_req", 64'(mem_req_o), 0);
        chk("arst_mem_fields", 64'({mem_we_o, mem_addr_o}), 0);
        chk("arst_mem_wdata", 64'(mem_wdata_o), 0);
        chk("arst_acks_err", 64'({inst_ack_o, data_ack_o, err_o}), 0);
        chk("arst_rdata", 64'({inst_rdata_o, data_rdata_o}), 0);
        data_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (inst_ack_o || data_ack_o || mem_req_o) acks++;
        end
        chk("no_activity_after_reset", 64'(acks), 0);
        push_mem(0, 32'h800, 0, 32'h00000088, 0, 1);
        push_ack(0, 32'h00000088, 0);
        do_fetch(32'h800, lat);
        chk("post_reset_fetch_latency", 64'(lat), 2);

        repeat (3) @(posedge clk);
        #1;
        chk("ack_queue_drained", 64'(aq.size()), 0);
        chk("mem_queue_drained", 64'(mq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-ported memory bus between the CPU instruction-fetch port and the data (load/store) port.
- Data requests have fixed priority, with a starvation guard for fetch.
- Each transfer is sequenced through an FSM with a per-transfer timeout.
- Sits between the pipelined core's inst/data interfaces and the memory/AXI bridge; the core stalls on the missing ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_STREAK, 4, maximum consecutive data grants while a fetch is pending.
- TIMEOUT_CYCLES, 64, BUSY cycles without mem_ready_i before the transfer is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- inst_req_i  in  1  fetch request; held with stable address until ack.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_ack_o  out  1  one-cycle completion pulse for fetch.
- inst_rdata_o  out  DATA_W  fetched word; valid with ack, held until the next fetch ack.
- data_req_i  in  1  data request; held with stable fields until ack.
- data_we_i  in  1  1 = store, 0 = load.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  DATA_W  store data.
- data_ack_o  out  1  one-cycle completion pulse for data.
- data_rdata_o  out  DATA_W  load data; valid with ack, held until the next data ack.
- err_o  out  1  pulses with an ack when that transfer timed out.
- mem_req_o  out  1  memory request; held until ready or timeout.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ready_i  in  1  transfer completes at the rising edge where mem_req_o=1 and mem_ready_i=1.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ready_i=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; streak=0; timeout counter=0.
  - All outputs 0, including both rdata registers.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated at the edge:
  - data_req_i=1 and (inst_req_i=0 or streak<MAX_STREAK) → BUSY_D; latch data fields onto mem_*.
  - else if inst_req_i=1 → BUSY_I; latch inst_addr_i; mem_we_o=0.
  - else stay in IDLE.
  - All mem_* outputs are registered; mem_req_o=1 exactly while in BUSY_*.
- Streak counter:
  - On a data grant with inst_req_i=1: streak++ (saturates at MAX_STREAK).
  - On any fetch grant, or a data grant with inst_req_i=0: streak=0.
- BUSY_x completion: edge with mem_ready_i=1.
  - Next cycle: x_ack_o=1 and x_rdata_o=mem_rdata_i.
  - For stores, data_rdata_o is unchanged.
  - mem_req_o=0; state=IDLE; timeout counter cleared.
- BUSY_x timeout: counter increments each BUSY cycle without ready; on reaching TIMEOUT_CYCLES:
  - Abort: mem_req_o=0.
  - Next cycle: x_ack_o=1, err_o=1, x_rdata_o=0.
  - State=IDLE.
- Ack cycle is IDLE:
  - A requester holding req high in its ack cycle is issuing a new request and is arbitrated that cycle.
  - Peak throughput is one transfer per 2 cycles.
  - Minimum latency is req seen at edge N → mem_req_o high in cycle N+1 → ready at edge N+1 → ack in cycle N+2.
- No change of grant mid-transfer. A requester dropping req while BUSY is a protocol violation; the transfer completes and the ack is still issued.
- inst_ack_o and data_ack_o are never high in the same cycle.
- err_o is only ever high together with an ack.
- Reset mid-transfer: immediate abort, no ack, mem_req_o drops asynchronously.

Test Plan:
- Single fetch:
  - Stimulus: inst_req_i=1, addr 0x100; memory ready the first cycle with 0x00500093.
  - Required: mem_req_o high 1 cycle with addr 0x100, we=0; inst_ack_o pulse 2 cycles after request; inst_rdata_o=0x00500093.
- Simultaneous requests:
  - Stimulus: fetch 0x200 and store 0xDEADBEEF→0x1000 raised together.
  - Required: store is granted first (mem_we_o=1, wdata 0xDEADBEEF), then the fetch; no ack overlap.
- Starvation guard (MAX_STREAK=4):
  - Stimulus: data_req_i held continuously, fetch pending.
  - Required: exactly 4 data transfers, then 1 fetch, then data resumes; streak returns to 0.
- Timeout (TIMEOUT_CYCLES=64):
  - Stimulus: load 0x2000, mem_ready_i held 0.
  - Required: mem_req_o drops after 64 cycles; next cycle data_ack_o=1, err_o=1, data_rdata_o=0; next fetch proceeds normally.
- Wait states:
  - Stimulus: ready delayed 3 cycles.
  - Required: mem_addr_o/we/wdata stable all 4 BUSY cycles; a single ack.
- Async reset mid-BUSY_D:
  - Stimulus: assert rst=0 mid-transfer.
  - Required: all outputs 0 immediately with no clock edge; no ack after release; clean IDLE arbitration afterwards.
